// File: rtl/bicubic_filter_if.sv
`default_nettype none
// ============================================================================
// bicubic_filter_if: window-in / pixel-out handshake bundle for bicubic_filter.
// Revision: 1.0
// ============================================================================
interface bicubic_filter_if;
    logic [14:0] in_0;
    logic [14:0] in_1;
    logic [14:0] in_2;
    logic [14:0] in_3;
    logic        in_valid;
    logic        in_ready;
    logic [14:0] out_pix;
    logic        out_valid;
`ifdef BICUBIC_PHASE_OUT_EN
    logic [1:0]  out_phase;

    modport master (
        output in_0, in_1, in_2, in_3, in_valid,
        input  in_ready, out_pix, out_valid, out_phase
    );
    modport slave (
        input  in_0, in_1, in_2, in_3, in_valid,
        output in_ready, out_pix, out_valid, out_phase
    );
`else
    modport master (
        output in_0, in_1, in_2, in_3, in_valid,
        input  in_ready, out_pix, out_valid
    );
    modport slave (
        input  in_0, in_1, in_2, in_3, in_valid,
        output in_ready, out_pix, out_valid
    );
`endif
endinterface
`default_nettype wire

// File: rtl/bicubic_filter.sv
`default_nettype none
// ============================================================================
// bicubic_filter: 4x Catmull-Rom upscaler, one 4-tap window in, four phases out.
// Optional out_phase port under BICUBIC_PHASE_OUT_EN.  Revision: 1.0
// ============================================================================
module bicubic_filter (
    input wire              clk,
    input wire              rst,
    bicubic_filter_if.slave bus
);
    localparam int PIX_W  = 15;
    localparam int ACC_W  = 25;
    localparam int COEF_W = 9;
    localparam logic signed [ACC_W-1:0] ROUND   = ACC_W'(64);
    localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'(32767);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [1:0]              phase_q, phase_d;
    logic [PIX_W-1:0]        hold_q [4];
    logic [PIX_W-1:0]        hold_d [4];
    logic signed [ACC_W-1:0] prod_q [4];
    logic signed [ACC_W-1:0] prod_d [4];
    logic                    s1_valid_q, s1_valid_d;
    logic [PIX_W-1:0]        out_pix_q, out_pix_d;
    logic                    out_valid_q, out_valid_d;
`ifdef BICUBIC_PHASE_OUT_EN
    logic [1:0]              s1_phase_q, s1_phase_d;
    logic [1:0]              out_phase_q, out_phase_d;
`endif

    logic                    ready;
    logic                    accept;
    logic [PIX_W-1:0]        win [4];
    logic signed [ACC_W-1:0] tap_ext  [4];
    logic signed [ACC_W-1:0] coef_ext [4];
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] shifted;

    // Catmull-Rom weights scaled by 128, indexed by {phase, tap}.
    function automatic logic signed [COEF_W-1:0] coef_lut(input logic [1:0] ph,
                                                          input logic [1:0] tap);
        logic signed [COEF_W-1:0] c;
        case ({ph, tap})
            4'h1:    c = 9'sd128;
            4'h4:    c = -9'sd9;
            4'h5:    c = 9'sd111;
            4'h6:    c = 9'sd29;
            4'h7:    c = -9'sd3;
            4'h8:    c = -9'sd8;
            4'h9:    c = 9'sd72;
            4'hA:    c = 9'sd72;
            4'hB:    c = -9'sd8;
            4'hC:    c = -9'sd3;
            4'hD:    c = 9'sd29;
            4'hE:    c = 9'sd111;
            4'hF:    c = -9'sd9;
            default: c = '0;
        endcase
        return c;
    endfunction

    // A new window may land on the phase-3 issue edge, keeping output gap-free.
    assign ready        = (state_q == ST_IDLE) || (phase_q == 2'd3);
    assign accept       = bus.in_valid && ready;
    assign bus.in_ready = ready;

    always_comb begin
        win[0] = bus.in_0;
        win[1] = bus.in_1;
        win[2] = bus.in_2;
        win[3] = bus.in_3;

        state_d = state_q;
        phase_d = phase_q;
        for (int i = 0; i < 4; i++) begin
            hold_d[i] = accept ? win[i] : hold_q[i];
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_ISSUE;
                    phase_d = 2'd0;
                end
            end
            ST_ISSUE: begin
                if (phase_q == 2'd3) begin
                    phase_d = 2'd0;
                    if (!accept) begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    phase_d = phase_q + 2'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                phase_d = 2'd0;
            end
        endcase
    end

    // Stage 1: four signed products for the phase being issued.
    always_comb begin
        s1_valid_d = (state_q == ST_ISSUE);
`ifdef BICUBIC_PHASE_OUT_EN
        s1_phase_d = (state_q == ST_ISSUE) ? phase_q : s1_phase_q;
`endif
        for (int i = 0; i < 4; i++) begin
            tap_ext[i]  = {{(ACC_W-PIX_W){1'b0}}, hold_q[i]};
            coef_ext[i] = coef_lut(phase_q, 2'(i));
            prod_d[i]   = (state_q == ST_ISSUE) ? (tap_ext[i] * coef_ext[i]) : prod_q[i];
        end
    end

    // Stage 2: round, scale back by 128 and clamp into the unsigned pixel range.
    always_comb begin
        sum         = prod_q[0] + prod_q[1] + prod_q[2] + prod_q[3];
        shifted     = (sum + ROUND) >>> 7;
        out_valid_d = s1_valid_q;
        out_pix_d   = out_pix_q;
        if (s1_valid_q) begin
            if (shifted[ACC_W-1]) begin
                out_pix_d = '0;
            end else if (shifted > PIX_MAX) begin
                out_pix_d = {PIX_W{1'b1}};
            end else begin
                out_pix_d = shifted[PIX_W-1:0];
            end
        end
`ifdef BICUBIC_PHASE_OUT_EN
        out_phase_d = s1_valid_q ? s1_phase_q : out_phase_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            phase_q     <= 2'd0;
            s1_valid_q  <= 1'b0;
            out_pix_q   <= '0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                hold_q[i] <= '0;
                prod_q[i] <= '0;
            end
`ifdef BICUBIC_PHASE_OUT_EN
            s1_phase_q  <= 2'd0;
            out_phase_q <= 2'd0;
`endif
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            s1_valid_q  <= s1_valid_d;
            out_pix_q   <= out_pix_d;
            out_valid_q <= out_valid_d;
            for (int i = 0; i < 4; i++) begin
                hold_q[i] <= hold_d[i];
                prod_q[i] <= prod_d[i];
            end
`ifdef BICUBIC_PHASE_OUT_EN
            s1_phase_q  <= s1_phase_d;
            out_phase_q <= out_phase_d;
`endif
        end
    end

    assign bus.out_pix   = out_pix_q;
    assign bus.out_valid = out_valid_q;
`ifdef BICUBIC_PHASE_OUT_EN
    assign bus.out_phase = out_phase_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bicubic_filter.sv
`default_nettype none
// tb_bicubic_filter: directed windows checked every cycle against a behavioural
// model of the 4x Catmull-Rom upscaler, plus hand-computed pixel lists.
module tb_bicubic_filter;
    localparam int MAXE = 4096;

    logic clk = 1'b0;
    logic rst = 1'b1;

    bicubic_filter_if bus ();

    bicubic_filter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    int edge_n   = 0;
    int last_cap = -100;
    bit exp_valid [MAXE];
    int exp_pix   [MAXE];
    int exp_phase [MAXE];
    bit exp_ready [MAXE];
    bit rst_edge  [MAXE];
    int last_pix  = 0;

    int got_pix   [$];
    int got_phase [$];
    int first_valid_edge = -1;
    int run_len   = 0;
    int max_run   = 0;
    int ready_cnt = 0;
    int burst_lo  = MAXE;
    int burst_hi  = MAXE;

    int CR [4][4] = '{'{0, 128, 0, 0}, '{-9, 111, 29, -3},
                      '{-8, 72, 72, -8}, '{-3, 29, 111, -9}};

    function automatic int interp(input int t0, input int t1, input int t2,
                                  input int t3, input int ph);
        int s;
        int r;
        s = CR[ph][0] * t0 + CR[ph][1] * t1 + CR[ph][2] * t2 + CR[ph][3] * t3;
        r = (s + 64) >>> 7;
        if (r < 0)     r = 0;
        if (r > 32767) r = 32767;
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // Model: a window accepted at edge e yields phases 0..3 after edges e+2..e+5;
    // a new window is taken once the previous one reaches its last issue edge.
    initial begin
        forever begin
            @(posedge clk);
            edge_n++;
            if (rst) begin
                for (int k = edge_n; k <= edge_n + 5; k++) exp_valid[k] = 1'b0;
                rst_edge[edge_n] = 1'b1;
                last_cap = -100;
            end else if (bus.in_valid && edge_n >= last_cap + 4) begin
                last_cap = edge_n;
                for (int p = 0; p < 4; p++) begin
                    exp_valid[edge_n + 2 + p] = 1'b1;
                    exp_pix[edge_n + 2 + p]   = interp(bus.in_0, bus.in_1, bus.in_2, bus.in_3, p);
                    exp_phase[edge_n + 2 + p] = p;
                end
            end
            exp_ready[edge_n] = (edge_n + 1 >= last_cap + 4);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (edge_n > 0) begin
                if (rst_edge[edge_n])       last_pix = 0;
                else if (exp_valid[edge_n]) last_pix = exp_pix[edge_n];
                check("out_valid", int'(bus.out_valid), int'(exp_valid[edge_n]));
                check("in_ready", int'(bus.in_ready), int'(exp_ready[edge_n]));
                check("out_pix", int'(bus.out_pix), last_pix);
`ifdef BICUBIC_PHASE_OUT_EN
                if (exp_valid[edge_n]) check("out_phase", int'(bus.out_phase), exp_phase[edge_n]);
`endif
                if (bus.out_valid) begin
                    got_pix.push_back(int'(bus.out_pix));
`ifdef BICUBIC_PHASE_OUT_EN
                    got_phase.push_back(int'(bus.out_phase));
`endif
                    if (first_valid_edge < 0) first_valid_edge = edge_n;
                    run_len++;
                    if (run_len > max_run) max_run = run_len;
                end else begin
                    run_len = 0;
                end
                if (bus.in_ready && edge_n >= burst_lo && edge_n <= burst_hi) ready_cnt++;
            end
        end
    end

    task automatic drive(input int a, input int b, input int c, input int d);
        int n;
        n = 0;
        bus.in_0     = 15'(a);
        bus.in_1     = 15'(b);
        bus.in_2     = 15'(c);
        bus.in_3     = 15'(d);
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: in_ready %0d, required 1", bus.in_ready);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic clear_got();
        got_pix.delete();
        got_phase.delete();
        first_valid_edge = -1;
    endtask

    task automatic check_list(input string name, input int e0, input int e1,
                              input int e2, input int e3);
        int e [4];
        e = '{e0, e1, e2, e3};
        check({name, "_count"}, got_pix.size(), 4);
        for (int i = 0; i < 4 && i < got_pix.size(); i++) begin
            check($sformatf("%s_pix%0d", name, i), got_pix[i], e[i]);
`ifdef BICUBIC_PHASE_OUT_EN
            check($sformatf("%s_phase%0d", name, i), got_phase[i], i);
`endif
        end
        clear_got();
    endtask

    initial begin
        int cap;
        int rst_e;
        int burst [12];

        bus.in_valid = 1'b0;
        bus.in_0 = '0;
        bus.in_1 = '0;
        bus.in_2 = '0;
        bus.in_3 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        drive(1000, 1000, 1000, 1000);
        cap = last_cap;
        repeat (8) @(negedge clk);
        check("flat_latency", first_valid_edge - cap, 2);
        check_list("flat", 1000, 1000, 1000, 1000);

        drive(0, 0, 100, 100);
        repeat (8) @(negedge clk);
        check_list("ramp", 0, 20, 50, 80);

        drive(0, 32767, 32767, 0);
        repeat (8) @(negedge clk);
        check_list("clamp_hi", 32767, 32767, 32767, 32767);

        drive(32767, 0, 0, 0);
        repeat (8) @(negedge clk);
        check_list("clamp_lo", 0, 0, 0, 0);

        drive(100, 200, 300, 400);
        repeat (8) @(negedge clk);
        check_list("linear", 200, 225, 250, 275);

        // Three windows back-to-back with in_valid held high.
        max_run = 0;
        drive(1000, 1000, 1000, 1000);
        burst_lo = last_cap;
        burst_hi = last_cap + 11;
        drive(0, 0, 100, 100);
        drive(100, 200, 300, 400);
        repeat (10) @(negedge clk);
        check("burst_ready_pulses", ready_cnt, 3);
        check("burst_valid_run", max_run, 12);
        check("burst_count", got_pix.size(), 12);
        burst = '{1000, 1000, 1000, 1000, 0, 20, 50, 80, 200, 225, 250, 275};
        for (int i = 0; i < 12 && i < got_pix.size(); i++) begin
            check($sformatf("burst_pix%0d", i), got_pix[i], burst[i]);
        end
        clear_got();

        // Reset after the phase-1 issue edge flushes the window.
        drive(1000, 1000, 1000, 1000);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rst_e = edge_n;
        check("pre_rst_count", got_pix.size(), 1);
        clear_got();
        drive(0, 0, 100, 100);
        check("rst_reaccept_edge", last_cap, rst_e + 1);
        repeat (8) @(negedge clk);
        check_list("post_rst", 0, 20, 50, 80);

        // Reset coincident with in_valid: window must not be captured.
        bus.in_0 = 15'd500;
        bus.in_1 = 15'd500;
        bus.in_2 = 15'd500;
        bus.in_3 = 15'd500;
        bus.in_valid = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        repeat (8) @(negedge clk);
        check("rst_wins_count", got_pix.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end
endmodule
`default_nettype wire
